// File: rtl/erm16_bus_pkg.sv
// Shared types and constants for the ERM16 bus arbiter slice.
package erm16_bus_pkg;

  localparam int unsigned ERM16_AW = 16;
  localparam int unsigned ERM16_DW = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } bus_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_DMA
  } bus_owner_t;

  // Burst count after a DMA grant: cleared when the DMA is not locking,
  // stepped (saturating) when the grant extends a DMA run, else held.
  function automatic logic [3:0] burst_next(input logic [3:0] cnt,
                                            input logic       lock,
                                            input logic       after_dma);
    logic [3:0] res;
    res = cnt;
    if (!lock) begin
      res = 4'd0;
    end else if (after_dma && (cnt != 4'hF)) begin
      res = cnt + 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/erm16_rr_pick.sv
// Combinational winner select between the core and the DMA engine.
module erm16_rr_pick
  import erm16_bus_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic       i_cpu_req,
  input  logic       i_dma_req,
  input  logic       i_dma_lock,
  input  bus_owner_t i_last_owner,
  input  logic [3:0] i_burst_cnt,
  output logic       o_valid,
  output bus_owner_t o_winner
);

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  logic w_lock_hold;

  // DMA may keep the bus on a tie while its locked burst is under the limit.
  assign w_lock_hold = (i_last_owner == OWN_DMA) && i_dma_lock && (i_burst_cnt < MaxBurst);

  // Single requester wins outright; a tie alternates unless the lock holds.
  always_comb begin
    o_valid  = i_cpu_req | i_dma_req;
    o_winner = OWN_CPU;
    if (i_cpu_req && i_dma_req) begin
      if (w_lock_hold) begin
        o_winner = OWN_DMA;
      end else if (i_last_owner == OWN_DMA) begin
        o_winner = OWN_CPU;
      end else begin
        o_winner = OWN_DMA;
      end
    end else if (i_dma_req) begin
      o_winner = OWN_DMA;
    end
  end

endmodule

// File: rtl/erm16_bus_arbiter.sv
// Two-master ERM16 bus arbiter: round-robin between core and DMA with a bounded
// DMA burst lock, fixed wait-state access phase and a one-cycle acknowledge.
module erm16_bus_arbiter
  import erm16_bus_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned MAX_BURST   = 4
) (
  input  logic                clk,
  input  logic                rst,
  // Core side
  input  logic                cpu_req,
  input  logic [ERM16_AW-1:0] cpu_addr,
  input  logic [ERM16_DW-1:0] cpu_wdata,
  input  logic                cpu_we,
  input  logic                cpu_io,
  output logic                cpu_ack,
  output logic [ERM16_DW-1:0] cpu_rdata,
  // DMA side
  input  logic                dma_req,
  input  logic [ERM16_AW-1:0] dma_addr,
  input  logic [ERM16_DW-1:0] dma_wdata,
  input  logic                dma_we,
  input  logic                dma_io,
  input  logic                dma_lock,
  output logic                dma_ack,
  output logic [ERM16_DW-1:0] dma_rdata,
  // Shared bus toward the memory/IO decoder
  output logic                mem_en,
  output logic [ERM16_AW-1:0] mem_addr,
  output logic [ERM16_DW-1:0] mem_wdata,
  output logic                mem_we,
  output logic                mem_ioe,
  input  logic [ERM16_DW-1:0] mem_rdata
);

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  bus_state_t          r_state;
  bus_owner_t          r_owner;
  bus_owner_t          r_last_owner;
  logic [3:0]          r_burst_cnt;
  logic [3:0]          r_wait_cnt;
  logic                r_cpu_ack;
  logic                r_dma_ack;
  logic [ERM16_DW-1:0] r_cpu_rdata;
  logic [ERM16_DW-1:0] r_dma_rdata;
  logic                r_mem_en;
  logic [ERM16_AW-1:0] r_mem_addr;
  logic [ERM16_DW-1:0] r_mem_wdata;
  logic                r_mem_we;
  logic                r_mem_ioe;

  logic                w_grant_valid;
  bus_owner_t          w_winner;
  logic [ERM16_AW-1:0] w_sel_addr;
  logic [ERM16_DW-1:0] w_sel_wdata;
  logic                w_sel_we;
  logic                w_sel_io;

  erm16_rr_pick #(
    .MAX_BURST (MAX_BURST)
  ) u_pick (
    .i_cpu_req    (cpu_req),
    .i_dma_req    (dma_req),
    .i_dma_lock   (dma_lock),
    .i_last_owner (r_last_owner),
    .i_burst_cnt  (r_burst_cnt),
    .o_valid      (w_grant_valid),
    .o_winner     (w_winner)
  );

  // Steer the winning requester's transfer fields toward the bus latches.
  always_comb begin
    w_sel_addr  = cpu_addr;
    w_sel_wdata = cpu_wdata;
    w_sel_we    = cpu_we;
    w_sel_io    = cpu_io;
    if (w_winner == OWN_DMA) begin
      w_sel_addr  = dma_addr;
      w_sel_wdata = dma_wdata;
      w_sel_we    = dma_we;
      w_sel_io    = dma_io;
    end
  end

  // Transfer sequencer: grant, wait-state access phase, acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_owner      <= OWN_CPU;
      r_last_owner <= OWN_DMA;
      r_burst_cnt  <= 4'd0;
      r_wait_cnt   <= 4'd0;
      r_cpu_ack    <= 1'b0;
      r_dma_ack    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dma_rdata  <= '0;
      r_mem_en     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_we     <= 1'b0;
      r_mem_ioe    <= 1'b0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_dma_ack <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_owner     <= w_winner;
            r_wait_cnt  <= WaitInit;
            r_mem_en    <= 1'b1;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_we    <= w_sel_we;
            r_mem_ioe   <= w_sel_io;
            r_state     <= ACCESS;
            if (w_winner == OWN_DMA) begin
              r_burst_cnt <= burst_next(r_burst_cnt, dma_lock, r_last_owner == OWN_DMA);
            end else begin
              r_burst_cnt <= 4'd0;
            end
          end
        end
        ACCESS: begin
          if (r_wait_cnt == 4'd0) begin
            // Last access cycle: the addressed device drives valid read data now.
            if (!r_mem_we) begin
              if (r_owner == OWN_DMA) begin
                r_dma_rdata <= mem_rdata;
              end else begin
                r_cpu_rdata <= mem_rdata;
              end
            end
            r_mem_en  <= 1'b0;
            r_mem_we  <= 1'b0;
            r_mem_ioe <= 1'b0;
            r_state   <= ACK;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
          end
        end
        ACK: begin
          if (r_owner == OWN_DMA) begin
            r_dma_ack <= 1'b1;
          end else begin
            r_cpu_ack <= 1'b1;
          end
          r_last_owner <= r_owner;
          r_state      <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign cpu_ack   = r_cpu_ack;
  assign dma_ack   = r_dma_ack;
  assign cpu_rdata = r_cpu_rdata;
  assign dma_rdata = r_dma_rdata;
  assign mem_en    = r_mem_en;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign mem_ioe   = r_mem_ioe;

endmodule

// File: doc/erm16_bus_arbiter.md
Name: erm16_bus_arbiter

Overview:
Two-master arbiter that shares the single ERM16 memory/IO bus between the ERM16 core and a DMA engine. It arbitrates requests round-robin, with a bounded DMA burst lock. It sequences each transfer through a fixed number of wait states and returns read data with a one-cycle acknowledge. It sits between the core's bus pins (ADDR_BUS/DO/DI/wrmem/ioe) and the memory/IO decoder.

Parameters:
WAIT_CYCLES, 1, extra memory wait states per access (0..15); access phase lasts WAIT_CYCLES+1 cycles
MAX_BURST, 4, max consecutive DMA grants under dma_lock while cpu_req is pending (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset
cpu_req  in  1  core requests a bus transfer
cpu_addr  in  16  core address
cpu_wdata  in  16  core write data
cpu_we  in  1  core write (1) / read (0)
cpu_io  in  1  core IO space (1) / memory space (0)
cpu_ack  out  1  one-cycle transfer-complete pulse to core
cpu_rdata  out  16  read data to core; valid while cpu_ack=1
dma_req, dma_addr, dma_wdata, dma_we, dma_io  in  1/16/16/1/1  DMA equivalents of the cpu_* inputs
dma_lock  in  1  DMA requests back-to-back ownership
dma_ack  out  1  one-cycle transfer-complete pulse to DMA
dma_rdata  out  16  read data to DMA; valid while dma_ack=1
mem_en  out  1  bus access active
mem_addr  out  16  bus address
mem_wdata  out  16  bus write data
mem_we  out  1  bus write strobe (the core's wrmem)
mem_ioe  out  1  IO-space select (the core's ioe)
mem_rdata  in  16  bus read data; sampled on the last access cycle

Behaviour:
- Reset is rst: synchronous, active-high.
- Reset values: state=IDLE; every output 0; owner=CPU; last_owner=DMA, so the CPU wins the first tie; burst count=0; wait count=0.
- FSM states: IDLE, ACCESS, ACK. All outputs are registered.
- IDLE: if any request is present on an edge, latch the winner's addr/wdata/we/io, set owner, and go to ACCESS. Otherwise stay in IDLE.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: the side that is not last_owner wins.
  - Exception: if last_owner=DMA, dma_lock=1 and burst count<MAX_BURST, DMA wins.
- Burst counter: increments on each DMA grant that follows a DMA grant. Resets to 0 on any CPU grant. Also resets to 0 when a DMA grant occurs with dma_lock=0.
- ACCESS:
  - mem_en=1; mem_addr/mem_wdata come from the latched values.
  - mem_we = latched we; mem_ioe = latched io.
  - Stays in ACCESS for WAIT_CYCLES+1 cycles, counted by a 4-bit down-counter.
  - On the final cycle, mem_rdata is captured into the owner's rdata register and the FSM goes to ACK.
- ACK:
  - mem_en, mem_we and mem_ioe drop to 0.
  - Owner's ack=1 for exactly one cycle; last_owner is set to owner.
  - Next state is IDLE; arbitration resumes on the following edge.
- Latency: request seen in IDLE at edge T gives ack high in the cycle after edge T+WAIT_CYCLES+2. Max throughput is one transfer per WAIT_CYCLES+3 cycles.
- Latched inputs: requester inputs are latched at grant, so changes during ACCESS have no effect. Requesters hold req until ack and may keep req high for back-to-back transfers.
- rdata: the non-owner's rdata holds its previous value. rdata is also held after ack until the next read by the same master; writes leave rdata unchanged.
- req drop mid-transfer: the transfer completes and ack is still pulsed; there is no abort.
- dma_lock with cpu_req=0: the DMA keeps the bus indefinitely; the burst limit applies only while cpu_req=1.
- mem_we is never high outside ACCESS; cpu_ack and dma_ack are never high together.
- rst mid-ACCESS: the access is aborted at that edge, all outputs are 0 from the next cycle, and no ack is issued.
- WAIT_CYCLES=0: ACCESS lasts a single cycle.

Decomposition:
- Package erm16_bus_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCESS, ACK} bus_state_t;
  - typedef enum logic {OWN_CPU, OWN_DMA} bus_owner_t;
  - constant ERM16_AW=16 and constant ERM16_DW=16.
- One sub-module, erm16_rr_pick: the combinational winner select from cpu_req, dma_req, dma_lock, last_owner, burst count and MAX_BURST. The FSM and datapath latches stay in the top level.

Test Plan:
- Reset then single CPU read, WAIT_CYCLES=1, cpu_addr=16'h0010, mem_rdata=16'hBEEF -> mem_en high 2 cycles with mem_addr=16'h0010 and mem_we=0; cpu_ack 1 cycle with cpu_rdata=16'hBEEF; dma_ack stays 0.
- CPU IO write, cpu_io=1, cpu_we=1, cpu_wdata=16'h00A5 -> mem_ioe=1, mem_we=1 and mem_wdata=16'h00A5 only during ACCESS; rdata unchanged.
- Both req held high continuously, dma_lock=0 -> grants alternate CPU, DMA, CPU, DMA; acks never overlap; one ack every 4 cycles.
- dma_lock=1 with cpu_req held high, MAX_BURST=4 -> the DMA gets the grant that starts the burst plus 4 further consecutive grants, then the CPU is granted, then DMA again.
- rst asserted during the 2nd ACCESS cycle of a DMA write -> mem_en and mem_we are 0 next cycle, no dma_ack; after release, a simultaneous request is won by the CPU.
- Requester changes cpu_addr 16'h0010->16'h0020 mid-ACCESS and drops cpu_req -> mem_addr stays 16'h0010 and cpu_ack still pulses once.
